pattern_count_engine: RTL and testbench

Memory-mastering accelerator for the pattern-count workload that the processor otherwise runs in software. It sits beside data memory in TopLevel and shares the same Start/Ack handshake. On launch it reads a PAT_W-bit pattern and a MSG_BYTES-byte message, then counts three things:
- pattern hits inside each byte;
- bytes containing at least one hit;
- hits across the whole bit stream, including windows that span byte boundaries.

The three results are written back to data memory. It is a parametrised successor to the fixed 5-bit/32-byte program: pattern width, message length, addresses and counter width are all configurable.

---
 rtl/pattern_count_engine_pkg.sv | 41 ++++
 rtl/pattern_window_match.sv | 23 ++
 rtl/pattern_count_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_pattern_count_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_count_engine_pkg.sv
// Shared types and helpers for the pattern-count accelerator: FSM state encoding,
// result slot offsets and saturating arithmetic.
package pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_PAT = 3'd1,
        ST_SCAN     = 3'd2,
        ST_WB0      = 3'd3,
        ST_WB1      = 3'd4,
        ST_WB2      = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam logic [1:0] RES_OFS_BYTE_HITS   = 2'd0;
    localparam logic [1:0] RES_OFS_BYTE_COUNT  = 2'd1;
    localparam logic [1:0] RES_OFS_STREAM_HITS = 2'd2;

    // Adds inc to acc and clamps the result at max_v instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input logic [31:0] max_v);
        logic [32:0] sum_s;
        sum_s = {1'b0, acc} + {1'b0, inc};
        if (sum_s > {1'b0, max_v}) begin
            sat_add = max_v;
        end else begin
            sat_add = sum_s[31:0];
        end
    endfunction

    // Narrows a counter to one memory byte, clamping at 255.
    function automatic logic [7:0] sat_byte(input logic [31:0] val);
        if (val > 32'd255) begin
            sat_byte = 8'd255;
        end else begin
            sat_byte = val[7:0];
        end
    endfunction

endpackage

// File: rtl/pattern_window_match.sv
// Combinational popcount of every PAT_W-bit window of vec_i (MSB-first, stride 1)
// that equals pat_i.
module pattern_window_match #(
    parameter int VEC_W     = 8,
    parameter int PAT_W     = 5,
    parameter int CNT_OUT_W = 3
) (
    input  logic [VEC_W-1:0]     vec_i,
    input  logic [PAT_W-1:0]     pat_i,
    output logic [CNT_OUT_W-1:0] count_o
);

    localparam int N_WIN = VEC_W - PAT_W + 1;

    // Slide the window one bit at a time so overlapping matches all count.
    always_comb begin
        count_o = '0;
        for (int j = 0; j < N_WIN; j++) begin
            count_o = count_o + CNT_OUT_W'(vec_i[VEC_W-1-j -: PAT_W] == pat_i);
        end
    end

endmodule

// File: rtl/pattern_count_engine.sv
// Memory-mastering pattern-count accelerator. Define PATTERN_WRITEBACK_EN to write the
// three results back to data memory; otherwise they appear only on the count ports.
module pattern_count_engine
    import pattern_pkg::*;
#(
    parameter int PAT_W     = 5,
    parameter int MSG_BYTES = 32,
    parameter int MSG_BASE  = 0,
    parameter int PAT_ADDR  = 32,
    parameter int RES_ADDR  = 33,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [7:0]        MemRdData,
    output logic              MemWrEn,
    output logic [7:0]        MemWrData,
    output logic [CNT_W-1:0]  ByteHits,
    output logic [CNT_W-1:0]  ByteCount,
    output logic [CNT_W-1:0]  StreamHits
);

    localparam int IDX_W   = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int IN_WIN  = 8 - PAT_W + 1;
    localparam int IN_CW   = $clog2(IN_WIN + 1);
    localparam int SPAN_CW = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
    localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                    : 32'((64'd1 << CNT_W) - 64'd1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-2:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   byte_hits_q, byte_hits_d;
    logic [CNT_W-1:0]   byte_count_q, byte_count_d;
    logic [CNT_W-1:0]   stream_hits_q, stream_hits_d;
    logic               start_q;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               launch_s;
    logic [IN_CW-1:0]   in_hits_s;
    logic [SPAN_CW-1:0] span_hits_s;
    logic [SPAN_CW-1:0] span_eff_s;
    logic [2*PAT_W-3:0] span_vec_s;

    assign launch_s   = start_q & ~Start;
    assign span_vec_s = {tail_q, MemRdData[7:9-PAT_W]};
    assign span_eff_s = (idx_q != '0) ? span_hits_s : '0;

    pattern_window_match #(
        .VEC_W     (8),
        .PAT_W     (PAT_W),
        .CNT_OUT_W (IN_CW)
    ) u_in_byte (
        .vec_i   (MemRdData),
        .pat_i   (pat_q),
        .count_o (in_hits_s)
    );

    // Spanning windows straddle the previous byte's tail and this byte's head.
    pattern_window_match #(
        .VEC_W     (2 * (PAT_W - 1)),
        .PAT_W     (PAT_W),
        .CNT_OUT_W (SPAN_CW)
    ) u_span (
        .vec_i   (span_vec_s),
        .pat_i   (pat_q),
        .count_o (span_hits_s)
    );

    // Next-state and datapath update for the scan sequence.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pat_d         = pat_q;
        tail_d        = tail_q;
        byte_hits_d   = byte_hits_q;
        byte_count_d  = byte_count_q;
        stream_hits_d = stream_hits_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    state_d = ST_LOAD_PAT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_PAT: begin
                state_d       = ST_SCAN;
                pat_d         = MemRdData[7:8-PAT_W];
                idx_d         = '0;
                tail_d        = '0;
                byte_hits_d   = '0;
                byte_count_d  = '0;
                stream_hits_d = '0;
            end
            ST_SCAN: begin
                byte_hits_d   = CNT_W'(sat_add(32'(byte_hits_q), 32'(in_hits_s), CNT_MAX));
                byte_count_d  = CNT_W'(sat_add(32'(byte_count_q),
                                               (in_hits_s != '0) ? 32'd1 : 32'd0, CNT_MAX));
                stream_hits_d = CNT_W'(sat_add(32'(stream_hits_q),
                                               32'(in_hits_s) + 32'(span_eff_s), CNT_MAX));
                tail_d        = MemRdData[PAT_W-2:0];
                if (idx_q == LAST_IDX) begin
`ifdef PATTERN_WRITEBACK_EN
                    state_d = ST_WB0;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
`ifdef PATTERN_WRITEBACK_EN
            ST_WB0:  state_d = ST_WB1;
            ST_WB1:  state_d = ST_WB2;
            ST_WB2:  state_d = ST_DONE;
`endif
            ST_DONE: begin
                if (Start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they are registered yet aligned.
    always_comb begin
        ack_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        addr_d = '0;
        case (state_d)
            ST_LOAD_PAT: addr_d = ADDR_W'(PAT_ADDR);
            ST_SCAN:     addr_d = ADDR_W'(MSG_BASE) + ADDR_W'(idx_d);
`ifdef PATTERN_WRITEBACK_EN
            ST_WB0:      addr_d = ADDR_W'(RES_ADDR) + ADDR_W'(RES_OFS_BYTE_HITS);
            ST_WB1:      addr_d = ADDR_W'(RES_ADDR) + ADDR_W'(RES_OFS_BYTE_COUNT);
            ST_WB2:      addr_d = ADDR_W'(RES_ADDR) + ADDR_W'(RES_OFS_STREAM_HITS);
`endif
            default:     addr_d = '0;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pat_q         <= '0;
            tail_q        <= '0;
            byte_hits_q   <= '0;
            byte_count_q  <= '0;
            stream_hits_q <= '0;
            start_q       <= 1'b0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pat_q         <= pat_d;
            tail_q        <= tail_d;
            byte_hits_q   <= byte_hits_d;
            byte_count_q  <= byte_count_d;
            stream_hits_q <= stream_hits_d;
            start_q       <= Start;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            addr_q        <= addr_d;
        end
    end

`ifdef PATTERN_WRITEBACK_EN
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;

    // Write strobe and data for the three result slots.
    always_comb begin
        wr_en_d   = (state_d == ST_WB0) || (state_d == ST_WB1) || (state_d == ST_WB2);
        wr_data_d = 8'd0;
        case (state_d)
            ST_WB0:  wr_data_d = sat_byte(32'(byte_hits_d));
            ST_WB1:  wr_data_d = sat_byte(32'(byte_count_d));
            ST_WB2:  wr_data_d = sat_byte(32'(stream_hits_d));
            default: wr_data_d = 8'd0;
        endcase
    end

    // Writeback output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    // A reset arriving during writeback must suppress the write at that edge.
    assign MemWrEn   = wr_en_q & ~Reset;
    assign MemWrData = wr_data_q;
`else
    assign MemWrEn   = 1'b0;
    assign MemWrData = 8'd0;
`endif

    assign Ack        = ack_q;
    assign Busy       = busy_q;
    assign MemAddr    = addr_q;
    assign ByteHits   = byte_hits_q;
    assign ByteCount  = byte_count_q;
    assign StreamHits = stream_hits_q;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Scoreboard bench: a default instance and a CNT_W=6 instance run in lockstep against
// a bit-stream reference model; a monitor checks every write and every Ack rise.
module tb_pattern_count_engine;

    localparam int PW    = 5;
    localparam int NB    = 32;
    localparam int PADDR = 32;
    localparam int RES   = 33;
`ifdef PATTERN_WRITEBACK_EN
    localparam int LAT = NB + 4;
`else
    localparam int LAT = NB + 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start;
    logic       ack0, busy0, wr0, ack1, busy1, wr1;
    logic [7:0] addr0, rd0, wd0, addr1, rd1, wd1;
    logic [7:0] bh0, bc0, sh0;
    logic [5:0] bh1, bc1, sh1;
    logic [7:0] mem [0:255];

    assign rd0 = mem[addr0];
    assign rd1 = mem[addr1];

    pattern_count_engine u_dut (
        .Clk(clk), .Reset(reset), .Start(start), .Ack(ack0), .Busy(busy0),
        .MemAddr(addr0), .MemRdData(rd0), .MemWrEn(wr0), .MemWrData(wd0),
        .ByteHits(bh0), .ByteCount(bc0), .StreamHits(sh0)
    );

    pattern_count_engine #(.CNT_W(6)) u_sat (
        .Clk(clk), .Reset(reset), .Start(start), .Ack(ack1), .Busy(busy1),
        .MemAddr(addr1), .MemRdData(rd1), .MemWrEn(wr1), .MemWrData(wd1),
        .ByteHits(bh1), .ByteCount(bc1), .StreamHits(sh1)
    );

    typedef struct { int bh0; int bc0; int sh0; int bh1; int bc1; int sh1; } exp_t;
    typedef struct { int addr; int d0; int d1; } wr_t;

    exp_t aq[$];
    wr_t  wq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   launch_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Load memory and push the expected outcome computed from the raw bit stream.
    task automatic prepare(input logic [7:0] pat_byte, input logic [7:0] fill, input bit rnd);
        logic           bits [NB*8];
        bit             byte_hit [NB];
        logic [PW-1:0]  pat;
        int             bh, bc, sh;
        bit             m;
        exp_t           e;
        wr_t            w;
        mem[PADDR] = pat_byte;
        for (int b = 0; b < NB; b++) begin
            mem[b] = rnd ? 8'($urandom) : fill;
            byte_hit[b] = 1'b0;
            for (int j = 0; j < 8; j++) bits[8*b+j] = mem[b][7-j];
        end
        pat = PW'(pat_byte >> (8 - PW));
        bh = 0; bc = 0; sh = 0;
        for (int p = 0; p <= NB*8 - PW; p++) begin
            m = 1'b1;
            for (int j = 0; j < PW; j++) if (bits[p+j] != pat[PW-1-j]) m = 1'b0;
            if (m) begin
                sh++;
                if ((p % 8) + PW <= 8) begin
                    bh++;
                    byte_hit[p/8] = 1'b1;
                end
            end
        end
        for (int b = 0; b < NB; b++) if (byte_hit[b]) bc++;
        e.bh0 = imin(bh, 255); e.bc0 = imin(bc, 255); e.sh0 = imin(sh, 255);
        e.bh1 = imin(bh, 63);  e.bc1 = imin(bc, 63);  e.sh1 = imin(sh, 63);
        aq.push_back(e);
`ifdef PATTERN_WRITEBACK_EN
        w.addr = RES;     w.d0 = e.bh0; w.d1 = e.bh1; wq.push_back(w);
        w.addr = RES + 1; w.d0 = e.bc0; w.d1 = e.bc1; wq.push_back(w);
        w.addr = RES + 2; w.d0 = e.sh0; w.d1 = e.sh1; wq.push_back(w);
`else
        w.addr = 0; w.d0 = 0; w.d1 = 0;
`endif
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        launch_cyc = cyc;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (ack0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ack0 !== 1'b1) chk("ack_timeout", 0, 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or raises Ack.
    initial begin : monitor
        exp_t e;
        wr_t  w;
        logic ack_prev;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wr0 === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", int'(addr0), w.addr);
                    chk("wr_data", int'(wd0), w.d0);
                    chk("sat_wr_en", int'(wr1), 1);
                    chk("sat_wr_data", int'(wd1), w.d1);
                end
            end
            if (ack0 === 1'b1 && ack_prev !== 1'b1) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = aq.pop_front();
                    chk("byte_hits", int'(bh0), e.bh0);
                    chk("byte_count", int'(bc0), e.bc0);
                    chk("stream_hits", int'(sh0), e.sh0);
                    chk("sat_byte_hits", int'(bh1), e.bh1);
                    chk("sat_byte_count", int'(bc1), e.bc1);
                    chk("sat_stream_hits", int'(sh1), e.sh1);
                    chk("ack_latency", cyc - launch_cyc - 1, LAT);
                    chk("busy_at_done", int'(busy0), 0);
                    chk("sat_ack", int'(ack1), 1);
                end
            end
            ack_prev = ack0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ack", int'(ack0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_wr_en", int'(wr0), 0);
        chk("rst_addr", int'(addr0), 0);
        chk("rst_wr_data", int'(wd0), 0);
        chk("rst_counts", int'(bh0) + int'(bc0) + int'(sh0), 0);
        reset = 1'b0;

        prepare(8'hA8, 8'hAA, 1'b0); kick(); wait_done();
        prepare(8'hF8, 8'hFF, 1'b0); kick(); wait_done();
        prepare(8'h98, 8'hCC, 1'b0); kick(); wait_done();

        // Abort mid-scan with Reset, then relaunch with Start held high in IDLE first.
        prepare(8'hA8, 8'hAA, 1'b0); kick();
        repeat (12) @(negedge clk);
        chk("scan_busy", int'(busy0), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ack", int'(ack0), 0);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_wr_en", int'(wr0), 0);
        chk("abort_byte_hits", int'(bh0), 0);
        chk("abort_byte_count", int'(bc0), 0);
        chk("abort_stream_hits", int'(sh0), 0);
        chk("abort_sat_hits", int'(bh1), 0);
        aq.delete();
        wq.delete();
        reset = 1'b0;

        prepare(8'hA8, 8'hAA, 1'b0);
        @(negedge clk);
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("held_start_idle", int'(busy0), 0);
        end
        start = 1'b0;
        launch_cyc = cyc;
        wait_done();

        // Start pulse while busy must be ignored.
        prepare(8'hA8, 8'hAA, 1'b0); kick();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pulse_busy", int'(busy0), 1);
        wait_done();

        repeat (5) begin
            prepare(8'($urandom), 8'h00, 1'b1); kick(); wait_done();
        end

        repeat (3) @(negedge clk);
        chk("pending_acks", aq.size(), 0);
        chk("pending_writes", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
